// File: rtl/ac3_seq_ctrl.sv
// ac3_seq_ctrl: sequencer for the ac3 output accumulator.
// Per tile: clear the 4 ac3 registers, steer n_ops groups of 4 ac2 partial
// sums into registers 0..3, pulse the quantization shift, then hold the
// results valid until downstream accepts. Repeats for n_tiles tiles.
//
// Optional feature macro: AC3_SEQ_STALL_CNT_EN
//   When defined, adds a 32-bit stall_cnt output. It counts cycles spent in
//   ACC with in_valid low plus cycles spent in OUT with out_ready low.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; all strobes low
// CLEAR | cl_en pulse; op counter and word index reset
// ACC   | in_ready high; each accepted word written to register w_en
// SHIFT | s_en pulse (quantization shift)
// OUT   | out_valid held until out_ready; then next tile or done

module ac3_seq_ctrl #(
    parameter int MNO = 288,
    parameter int MNT = 256,
    localparam int OPW = $clog2(MNO + 1),
    localparam int TW  = $clog2(MNT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] n_ops,
    input  logic [TW-1:0]  n_tiles,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           valid,
    output logic [1:0]     w_en,
    output logic           cl_en,
    output logic           s_en,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef AC3_SEQ_STALL_CNT_EN
    output logic [31:0]    stall_cnt,
`endif
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACC   = 3'd2,
        SHIFT = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [OPW-1:0] MNO_V = OPW'(MNO);
    localparam logic [OPW-1:0] OP_ONE = OPW'(1);
    localparam logic [TW-1:0]  T_ONE  = TW'(1);

    state_t         state;
    logic [OPW-1:0] ops_lat;
    logic [TW-1:0]  tiles_lat;
    logic [OPW-1:0] op_cnt;
    logic [TW-1:0]  tile_cnt;

    logic           last_word;
    logic           last_tile;

    // The write strobe is the handshake itself; in_ready is only high in ACC.
    assign valid = in_valid & in_ready;

    // Word 3 of the final op group ends accumulation; ops_lat >= 1 in ACC.
    assign last_word = (w_en == 2'd3) && (op_cnt == (ops_lat - OP_ONE));
    // tiles_lat is never 0 after latch, so the subtraction cannot underflow.
    assign last_tile = (tile_cnt == (tiles_lat - T_ONE));

    // Main sequencer with registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ops_lat   <= '0;
            tiles_lat <= '0;
            op_cnt    <= '0;
            tile_cnt  <= '0;
            in_ready  <= 1'b0;
            w_en      <= 2'd0;
            cl_en     <= 1'b0;
            s_en      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ops_lat   <= (n_ops > MNO_V) ? MNO_V : n_ops;
                        tiles_lat <= (n_tiles == '0) ? T_ONE : n_tiles;
                        tile_cnt  <= '0;
                        op_cnt    <= '0;
                        w_en      <= 2'd0;
                        cl_en     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end

                CLEAR: begin
                    cl_en  <= 1'b0;
                    op_cnt <= '0;
                    w_en   <= 2'd0;
                    if (ops_lat == '0) begin
                        s_en  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ACC;
                    end
                end

                ACC: begin
                    if (in_valid) begin
                        w_en <= w_en + 2'd1;
                        if (w_en == 2'd3) begin
                            op_cnt <= op_cnt + OP_ONE;
                        end
                        if (last_word) begin
                            in_ready <= 1'b0;
                            s_en     <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    s_en      <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_tile) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            tile_cnt <= tile_cnt + T_ONE;
                            cl_en    <= 1'b1;
                            state    <= CLEAR;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    cl_en     <= 1'b0;
                    s_en      <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef AC3_SEQ_STALL_CNT_EN
    logic stall_now;

    assign stall_now = ((state == ACC) && !in_valid) ||
                       ((state == OUT) && !out_ready);

    // Saturating stall counter, restarted on every accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ac3_seq_ctrl.sv
// Directed testbench for ac3_seq_ctrl (MNO=288, MNT=256).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the rising edge.

module tb_ac3_seq_ctrl;

    localparam int MNO = 288;
    localparam int MNT = 256;
    localparam int OPW = $clog2(MNO + 1);
    localparam int TW  = $clog2(MNT + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [OPW-1:0] n_ops = '0;
    logic [TW-1:0]  n_tiles = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           valid;
    logic [1:0]     w_en;
    logic           cl_en;
    logic           s_en;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           done;
`ifdef AC3_SEQ_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ac3_seq_ctrl #(.MNO(MNO), .MNT(MNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_ops     (n_ops),
        .n_tiles   (n_tiles),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .valid     (valid),
        .w_en      (w_en),
        .cl_en     (cl_en),
        .s_en      (s_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AC3_SEQ_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; returns 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle then compare all control outputs against one expected vector.
    task automatic chk_all(input string tag, input logic e_rdy, input logic e_val,
                           input logic [1:0] e_w, input logic e_cl, input logic e_s,
                           input logic e_ov, input logic e_busy, input logic e_done);
        #1;
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_rdy});
        chk({tag, ".valid"},     {31'd0, valid},     {31'd0, e_val});
        chk({tag, ".w_en"},      {30'd0, w_en},      {30'd0, e_w});
        chk({tag, ".cl_en"},     {31'd0, cl_en},     {31'd0, e_cl});
        chk({tag, ".s_en"},      {31'd0, s_en},      {31'd0, e_s});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, e_busy});
        chk({tag, ".done"},      {31'd0, done},      {31'd0, e_done});
    endtask

    // Runs a job with in_valid=1 and out_ready=1 held, counting strobes.
    task automatic run_counted(input int ops, input int tiles, input int budget,
                               output int n_cl, output int n_val, output int n_s,
                               output int n_ov, output int n_done, output int n_werr,
                               output int n_cyc);
        int widx;
        n_cl = 0; n_val = 0; n_s = 0; n_ov = 0; n_done = 0; n_werr = 0; n_cyc = 0;
        widx = 0;
        cyc();
        start = 1'b1; n_ops = OPW'(ops); n_tiles = TW'(tiles);
        in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        while (n_cyc < budget && n_done == 0) begin
            #1;
            if (cl_en) begin n_cl++; widx = 0; end
            if (valid) begin
                if (int'(w_en) != widx) n_werr++;
                widx = (widx + 1) % 4;
                n_val++;
            end
            if (s_en) n_s++;
            if (out_valid) n_ov++;
            if (done) n_done++;
            n_cyc++;
            if (n_done == 0) cyc();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    int n_cl, n_val, n_s, n_ov, n_done, n_werr, n_cyc;
    logic [0:6] gap_seq;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        #12;
        chk_all("reset", 0, 0, 2'd0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- basic: n_ops=2, n_tiles=1 ----------------
        cyc();
        start = 1'b1; n_ops = 9'd2; n_tiles = 9'd1; in_valid = 1'b1;     // t0
        chk_all("basic.t0", 0, 0, 2'd0, 0, 0, 0, 0, 0);
        cyc(); start = 1'b0;                                              // t1
        chk_all("basic.t1", 0, 0, 2'd0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin                                 // t2..t9
            cyc();
            chk_all($sformatf("basic.t%0d", i + 2), 1, 1, 2'(i % 4), 0, 0, 0, 1, 0);
        end
        cyc();                                                            // t10
        chk_all("basic.t10", 0, 0, 2'd0, 0, 1, 0, 1, 0);
        cyc();                                                            // t11
        chk_all("basic.t11", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc();                                                            // t12
        chk_all("basic.t12", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc(); out_ready = 1'b1;                                          // t13
        chk_all("basic.t13", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc(); out_ready = 1'b0; in_valid = 1'b0;                         // t14
        chk_all("basic.t14", 0, 0, 2'd0, 0, 0, 0, 0, 1);
        cyc();                                                            // t15
        chk_all("basic.t15", 0, 0, 2'd0, 0, 0, 0, 0, 0);

        // ---------------- gaps: n_ops=1, in_valid 1,0,0,1,1,0,1 ----------------
        gap_seq = 7'b1001101;
        cyc(); start = 1'b1; n_ops = 9'd1; n_tiles = 9'd1;
        cyc(); start = 1'b0;
        chk_all("gap.clear", 0, 0, 2'd0, 1, 0, 0, 1, 0);
        begin
            logic [1:0] exp_w;
            exp_w = 2'd0;
            for (int i = 0; i < 7; i++) begin
                cyc();
                in_valid = gap_seq[i];
                chk_all($sformatf("gap.acc%0d", i), 1, gap_seq[i], exp_w, 0, 0, 0, 1, 0);
                if (gap_seq[i]) exp_w = exp_w + 2'd1;
            end
        end
        cyc(); in_valid = 1'b0;
        chk_all("gap.shift", 0, 0, 2'd0, 0, 1, 0, 1, 0);
`ifdef AC3_SEQ_STALL_CNT_EN
        chk("gap.stall_cnt", stall_cnt, 32'd3);
`endif
        cyc(); out_ready = 1'b1;
        chk_all("gap.out", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc(); out_ready = 1'b0;
        chk_all("gap.done", 0, 0, 2'd0, 0, 0, 0, 0, 1);

        // ---------------- multi-tile: n_tiles=3, n_ops=3 ----------------
        run_counted(3, 3, 500, n_cl, n_val, n_s, n_ov, n_done, n_werr, n_cyc);
        chk("multi.cl_en",     n_cl,   3);
        chk("multi.valid",     n_val,  36);
        chk("multi.s_en",      n_s,    3);
        chk("multi.out_valid", n_ov,   3);
        chk("multi.done",      n_done, 1);
        chk("multi.w_en_seq",  n_werr, 0);
        cyc();
        chk_all("multi.idle", 0, 0, 2'd0, 0, 0, 0, 0, 0);

        // ---------------- n_tiles=0 treated as 1 ----------------
        run_counted(1, 0, 100, n_cl, n_val, n_s, n_ov, n_done, n_werr, n_cyc);
        chk("t0.cl_en", n_cl,  1);
        chk("t0.valid", n_val, 4);
        chk("t0.done",  n_done, 1);

        // ---------------- boundary: n_ops=0 ----------------
        cyc(); start = 1'b1; n_ops = 9'd0; n_tiles = 9'd1; in_valid = 1'b1;
        cyc(); start = 1'b0;
        chk_all("op0.clear", 0, 0, 2'd0, 1, 0, 0, 1, 0);
        cyc();
        chk_all("op0.shift", 0, 0, 2'd0, 0, 1, 0, 1, 0);
        cyc(); out_ready = 1'b1;
        chk_all("op0.out", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc(); out_ready = 1'b0; in_valid = 1'b0;
        chk_all("op0.done", 0, 0, 2'd0, 0, 0, 0, 0, 1);

        // ---------------- boundary: n_ops=511 clamps to MNO ----------------
        run_counted(511, 1, 2000, n_cl, n_val, n_s, n_ov, n_done, n_werr, n_cyc);
        chk("mno.valid",  n_val,  4 * MNO);
        chk("mno.w_en",   n_werr, 0);
        chk("mno.s_en",   n_s,    1);
        chk("mno.done",   n_done, 1);

        // ---------------- ignored inputs ----------------
        cyc(); start = 1'b1; n_ops = 9'd1; n_tiles = 9'd1;
        cyc(); start = 1'b0;
        cyc();                                                  // ACC, in_valid=0
        start = 1'b1; n_ops = 9'd5; n_tiles = 9'd4;
        chk_all("ign.acc0", 1, 0, 2'd0, 0, 0, 0, 1, 0);
        cyc(); start = 1'b0; in_valid = 1'b1;
        chk_all("ign.acc1", 1, 1, 2'd0, 0, 0, 0, 1, 0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk_all($sformatf("ign.acc_w%0d", i), 1, 1, 2'(i), 0, 0, 0, 1, 0);
        end
        cyc();
        chk_all("ign.shift", 0, 0, 2'd0, 0, 1, 0, 1, 0);
        cyc();
        chk_all("ign.out0", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc();
        chk_all("ign.out1", 0, 0, 2'd0, 0, 0, 1, 1, 0);
        cyc(); in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk_all("ign.done", 0, 0, 2'd0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin                      // out_ready in IDLE
            cyc();
            chk_all($sformatf("ign.idle%0d", i), 0, 0, 2'd0, 0, 0, 0, 0, 0);
        end
        out_ready = 1'b0;

        // ---------------- reset mid-ACC (op 5 of 9) then restart ----------------
        cyc(); start = 1'b1; n_ops = 9'd9; n_tiles = 9'd2; in_valid = 1'b1;
        cyc(); start = 1'b0;                                  // CLEAR
        for (int i = 0; i < 17; i++) cyc();                   // 16 words + first of op 5
        #1;
        chk("rst.pre_w_en",  {30'd0, w_en},  32'd0);
        chk("rst.pre_valid", {31'd0, valid}, 32'd1);
        rst = 1'b1;
        chk_all("rst.async", 0, 0, 2'd0, 0, 0, 0, 0, 0);
        cyc();
        chk_all("rst.hold", 0, 0, 2'd0, 0, 0, 0, 0, 0);
        rst = 1'b0; in_valid = 1'b0;
        run_counted(1, 1, 100, n_cl, n_val, n_s, n_ov, n_done, n_werr, n_cyc);
        chk("restart.cl_en", n_cl,   1);
        chk("restart.valid", n_val,  4);
        chk("restart.done",  n_done, 1);
        chk("restart.w_en",  n_werr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
